// File: rtl/freq_divider_bank.sv
// Bank of N_CH programmable dividers: 50% square wave plus one-cycle tick per channel.
// Latency: registered outputs, divisor write visible next cycle; no backpressure, free-running.
module freq_divider_bank #(
  parameter int N_CH        = 4,
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 25000000
) (
  input  logic                                   CLOCK_50,
  input  logic                                   RESET_N,
  input  logic [N_CH-1:0]                        en,
  input  logic                                   wr_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [WIDTH-1:0]                       wr_div,
  output logic [N_CH-1:0]                        sq_out,
  output logic [N_CH-1:0]                        tick,
  output logic [N_CH*WIDTH-1:0]                  div_rd
);

  localparam int WR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;
    logic             sq;
    logic             tick;
  } ch_t;

  ch_t ch_q [N_CH];
  ch_t ch_d [N_CH];

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int c = 0; c < N_CH; c++) begin
        ch_q[c] <= '{div: WIDTH'(DEFAULT_DIV), cnt: '0, sq: 1'b0, tick: 1'b0};
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        ch_q[c] <= ch_d[c];
      end
    end
  end

  // Out-of-range wr_ch never matches any channel index, so such writes fall through.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      ch_d[c]      = ch_q[c];
      ch_d[c].tick = 1'b0;
      if (wr_en && (wr_ch == WR_W'(c))) begin
        ch_d[c].div = wr_div;
        ch_d[c].cnt = '0;
      end else if (!en[c] || (ch_q[c].div == '0)) begin
        ch_d[c].cnt = ch_q[c].cnt;
      end else if (ch_q[c].cnt == ch_q[c].div - WIDTH'(1)) begin
        ch_d[c].cnt  = '0;
        ch_d[c].sq   = ~ch_q[c].sq;
        ch_d[c].tick = 1'b1;
      end else begin
        ch_d[c].cnt = ch_q[c].cnt + WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_out
    assign sq_out[g]                  = ch_q[g].sq;
    assign tick[g]                    = ch_q[g].tick;
    assign div_rd[g*WIDTH +: WIDTH]   = ch_q[g].div;
  end

endmodule

// File: tb/tb_freq_divider_bank.sv
// Directed scoreboard bench for freq_divider_bank (3 channels, 4-bit divisors, default 5).
module tb_freq_divider_bank;

  localparam int N_CH = 3;
  localparam int W    = 4;

  logic            CLOCK_50 = 1'b0;
  logic            RESET_N  = 1'b0;
  logic [N_CH-1:0] en       = '1;
  logic            wr_en    = 1'b0;
  logic [1:0]      wr_ch    = '0;
  logic [W-1:0]    wr_div   = '0;
  logic [N_CH-1:0] sq_out;
  logic [N_CH-1:0] tick;
  logic [N_CH*W-1:0] div_rd;

  freq_divider_bank #(.N_CH(N_CH), .WIDTH(W), .DEFAULT_DIV(5)) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .en       (en),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .sq_out   (sq_out),
    .tick     (tick),
    .div_rd   (div_rd)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Signal selectors for scoreboard entries.
  localparam int S_TICK = 0;
  localparam int S_SQ   = 1;
  localparam int S_DIV  = 2;

  typedef struct {
    int    cyc;
    int    sig;
    int    ch;
    int    val;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  function automatic void push(int c, int s, int ch, int v, string nm);
    exp_t e;
    e.cyc = c; e.sig = s; e.ch = ch; e.val = v; e.nm = nm;
    sb.push_back(e);
  endfunction

  function automatic int act(int s, int ch);
    case (s)
      S_TICK:  return tick[ch] ? 1 : 0;
      S_SQ:    return sq_out[ch] ? 1 : 0;
      default: return int'(div_rd[ch*W +: W]);
    endcase
  endfunction

  // Edge counter: cyc = number of rising edges seen so far.
  initial forever begin
    @(posedge CLOCK_50);
    cyc++;
  end

  // Monitor: outputs are presented every cycle; compare entries due this cycle.
  initial begin
    exp_t cur;
    forever begin
      @(negedge CLOCK_50);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        cur = sb.pop_front();
        total++;
        if (cur.cyc != cyc) begin
          bad++;
          $display("FAIL %s ch=%0d: check for cycle %0d not reached in time (now %0d)",
                   cur.nm, cur.ch, cur.cyc, cyc);
        end else if (act(cur.sig, cur.ch) != cur.val) begin
          bad++;
          $display("FAIL %s cyc=%0d ch=%0d got=%0d want=%0d",
                   cur.nm, cyc, cur.ch, act(cur.sig, cur.ch), cur.val);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: stimulus did not complete (cyc=%0d)", cyc);
    $fatal(1);
  end

  task automatic go(int c);
    while (cyc != c) @(negedge CLOCK_50);
  endtask

  initial begin
    // Reset held for 3 edges, then default divisor 5 on every channel.
    for (int c = 1; c <= 3; c++)
      for (int ch = 0; ch < N_CH; ch++) begin
        push(c, S_TICK, ch, 0, "rst_tick");
        push(c, S_SQ,   ch, 0, "rst_sq");
        push(c, S_DIV,  ch, 5, "rst_div");
      end
    for (int k = 1; k <= 15; k++)
      for (int ch = 0; ch < N_CH; ch++) begin
        push(3 + k, S_TICK, ch, (k % 5 == 0) ? 1 : 0, "def_tick");
        push(3 + k, S_SQ,   ch, (k / 5) % 2,          "def_sq");
      end
    go(3);
    RESET_N = 1'b1;

    // Per-channel divisors: ch0=3, ch1=4 written with all channels paused.
    go(18);
    for (int ch = 0; ch < N_CH; ch++) push(19, S_TICK, ch, 0, "wr_tick");
    push(19, S_DIV, 0, 3, "wr_div0");
    push(19, S_DIV, 1, 5, "wr_div1_untouched");
    for (int ch = 0; ch < N_CH; ch++) push(20, S_TICK, ch, 0, "wr_tick");
    push(20, S_DIV, 0, 3, "wr_div0");
    push(20, S_DIV, 1, 4, "wr_div1");
    for (int k = 1; k <= 12; k++) begin
      push(20 + k, S_TICK, 0, (k % 3 == 0) ? 1 : 0, "d3_tick");
      push(20 + k, S_TICK, 1, (k % 4 == 0) ? 1 : 0, "d4_tick");
      push(20 + k, S_TICK, 2, (k % 5 == 0) ? 1 : 0, "d5_tick");
    end
    en = 3'b000; wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd3;
    go(19);
    wr_ch = 2'd1; wr_div = 4'd4;
    go(20);
    wr_en = 1'b0; en = 3'b111;

    // Edge divisors: ch0=1, ch1=0 (halted), ch2=15.
    go(32);
    push(33, S_TICK, 0, 0, "d1_tick_wr");
    push(33, S_SQ,   0, 1, "d1_sq_hold");
    for (int j = 2; j <= 33; j++) begin
      push(32 + j, S_TICK, 0, 1, "d1_tick");
      push(32 + j, S_SQ,   0, (j % 2 == 0) ? 0 : 1, "d1_sq");
      if (j >= 3) begin
        push(32 + j, S_TICK, 1, 0, "d0_tick");
        push(32 + j, S_SQ,   1, 0, "d0_sq");
      end
      if (j == 3) push(32 + j, S_DIV, 2, 15, "d15_div");
      if (j >= 4) push(32 + j, S_TICK, 2, ((j - 3) % 15 == 0) ? 1 : 0, "d15_tick");
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd1;
    go(33);
    wr_ch = 2'd1; wr_div = 4'd0;
    go(34);
    wr_ch = 2'd2; wr_div = 4'd15;
    go(35);
    wr_en = 1'b0;

    // Enable pause on ch0 with D=6: 4 counts, 10 paused, tick 2 enabled cycles after resume.
    go(65);
    push(66, S_DIV,  0, 6, "pz_div");
    push(66, S_TICK, 0, 0, "pz_tick");
    for (int j = 1; j <= 18; j++) begin
      push(66 + j, S_TICK, 0, (j == 16) ? 1 : 0, "pz_tick");
      if (j == 15) push(66 + j, S_SQ, 0, 1, "pz_sq_before");
      if (j == 16) push(66 + j, S_SQ, 0, 0, "pz_sq_after");
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd6;
    go(66);
    wr_en = 1'b0;
    go(70);
    en = 3'b110;
    go(80);
    en = 3'b111;

    // Write collision on ch0 (D=4, write 7 at terminal count), ch2 D=4 as reference,
    // ignored write to wr_ch=3, then async reset between edges.
    go(84);
    for (int j = 1; j <= 27; j++) begin
      push(84 + j, S_TICK, 0, (j == 12 || j == 19 || j == 26) ? 1 : 0, "col_tick0");
      if (j == 5)             push(84 + j, S_SQ, 0, 0, "col_sq_held");
      if (j == 12)            push(84 + j, S_SQ, 0, 1, "col_sq_next");
      if (j == 19)            push(84 + j, S_SQ, 0, 0, "col_sq_next2");
      if (j == 26 || j == 27) push(84 + j, S_SQ, 0, 1, "col_sq_pre_rst");
      if (j >= 3) push(84 + j, S_TICK, 2, (j >= 6 && (j - 2) % 4 == 0) ? 1 : 0, "col_tick2");
      if (j == 15) begin
        push(84 + j, S_DIV, 0, 7, "ign_div0");
        push(84 + j, S_DIV, 1, 0, "ign_div1");
        push(84 + j, S_DIV, 2, 4, "ign_div2");
      end
    end
    for (int ch = 0; ch < N_CH; ch++) begin
      push(112, S_TICK, ch, 0, "arst_tick");
      push(112, S_SQ,   ch, 0, "arst_sq");
      push(112, S_DIV,  ch, 5, "arst_div");
    end
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd4;
    go(85);
    wr_ch = 2'd2; wr_div = 4'd4;
    go(86);
    wr_en = 1'b0;
    go(88);
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 4'd7;
    go(89);
    wr_en = 1'b0;
    go(98);
    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 4'd9;
    go(99);
    wr_en = 1'b0;
    go(111);
    @(posedge CLOCK_50);
    #2;
    RESET_N = 1'b0;
    go(115);
    RESET_N = 1'b1;
    go(116);

    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain: %0d checks left unconsumed, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
